// File: rtl/udc_sequencer.sv
// Run/hold sequencer for the lab-board 4-bit up/down counter: button sync/edge detect,
// prescaled step strobes, target stop. Define UDC_AUTO_REVERSE_EN for ping-pong at 0/15.
module udc_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int PW       = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_stop,
   input  logic       btn_clr,
   input  logic [3:0] tgt,
   input  logic       tgt_en,
   input  logic [3:0] cnt_val,
   output logic       cnt_en,
   output logic       cnt_dir,
   output logic       cnt_clr,
   output logic [1:0] st,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_RUN_UP   = 2'b01,
      S_RUN_DOWN = 2'b10,
      S_HOLD     = 2'b11
   } state_t;

   localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

   logic [3:0]    btn_raw;
   logic [3:0]    s1_q, s2_q, s3_q;
   logic [3:0]    blk_q;
   logic [1:0]    settle_q;
   logic [3:0]    cmd;
   logic          cmd_clr, cmd_stop, cmd_up, cmd_down;

   state_t        st_q;
   logic [PW-1:0] psc_q, psc_d;
   logic          tick;
   logic          running;
   logic          cnt_en_q, cnt_dir_q, cnt_clr_q, done_q;

   assign btn_raw = {btn_clr, btn_stop, btn_up, btn_down};

   // Buttons held through reset are blocked until the synchronized level is seen low,
   // so a press that started before reset never becomes a command afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         settle_q <= '0;
         blk_q    <= btn_raw;
      end else begin
         s1_q     <= btn_raw;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         settle_q <= {settle_q[0], 1'b1};
         if (settle_q[1]) blk_q <= blk_q & s2_q;
      end
   end

   assign cmd      = s2_q & ~s3_q & ~blk_q;
   assign cmd_clr  = cmd[3];
   assign cmd_stop = cmd[2];
   assign cmd_up   = cmd[1];
   assign cmd_down = cmd[0];

   assign running = (st_q == S_RUN_UP) || (st_q == S_RUN_DOWN);
   assign tick    = (psc_q == PSC_MAX);

   always_comb begin
      psc_d = psc_q + PW'(1);
      if (tick) psc_d = '0;
   end

   // Commands take priority over tick processing; a repeated command for the
   // current run direction falls through so the prescaler keeps its phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= S_IDLE;
         psc_q     <= '0;
         cnt_en_q  <= 1'b0;
         cnt_dir_q <= 1'b1;
         cnt_clr_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_en_q  <= 1'b0;
         cnt_clr_q <= 1'b0;
         done_q    <= 1'b0;
         if (cmd_clr) begin
            st_q      <= S_IDLE;
            psc_q     <= '0;
            cnt_clr_q <= 1'b1;
         end else if (cmd_stop && running) begin
            st_q  <= S_HOLD;
            psc_q <= '0;
         end else if (cmd_up && st_q != S_RUN_UP) begin
            st_q  <= S_RUN_UP;
            psc_q <= '0;
         end else if (cmd_down && !cmd_up && st_q != S_RUN_DOWN) begin
            st_q  <= S_RUN_DOWN;
            psc_q <= '0;
         end else if (running) begin
            psc_q <= psc_d;
            if (tick) begin
               if (tgt_en && cnt_val == tgt) begin
                  st_q   <= S_HOLD;
                  done_q <= 1'b1;
               end else begin
                  cnt_en_q <= 1'b1;
`ifdef UDC_AUTO_REVERSE_EN
                  if (st_q == S_RUN_UP && cnt_val == 4'hF) begin
                     st_q      <= S_RUN_DOWN;
                     cnt_dir_q <= 1'b0;
                  end else if (st_q == S_RUN_DOWN && cnt_val == 4'h0) begin
                     st_q      <= S_RUN_UP;
                     cnt_dir_q <= 1'b1;
                  end else begin
                     cnt_dir_q <= (st_q == S_RUN_UP);
                  end
`else
                  cnt_dir_q <= (st_q == S_RUN_UP);
`endif
               end
            end
         end else begin
            psc_q <= '0;
         end
      end
   end

   assign cnt_en  = cnt_en_q;
   assign cnt_dir = cnt_dir_q;
   assign cnt_clr = cnt_clr_q;
   assign done    = done_q;
   assign st      = st_q;
   assign busy    = running;

endmodule

// File: doc/udc_sequencer.md
# udc_sequencer

Sequencing controller for the 4-bit up/down counter datapath on the lab board. It takes raw push-button commands (up, down, stop, clear) and synchronizes and edge-detects them. A run/hold state machine then issues prescaled one-cycle count-enable pulses, a direction select and a clear strobe to the counter. It reads the counter value back so it can halt at a programmable target and handle the 0/15 boundaries.

## Interface
- TICK_DIV, 4, clk cycles between successive count-enable pulses while running (≥2; board builds override to ~50_000_000)
- PW, 26, prescaler width; must hold TICK_DIV-1

- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_up  input  1  raw button: run counting up
- btn_down  input  1  raw button: run counting down
- btn_stop  input  1  raw button: hold
- btn_clr  input  1  raw button: clear counter, go idle
- tgt  input  4  target count value
- tgt_en  input  1  enable stop-at-target
- cnt_val  input  4  current counter value (feedback)
- cnt_en  output  1  one-cycle count step strobe
- cnt_dir  output  1  1 = up, 0 = down; valid whenever cnt_en is high
- cnt_clr  output  1  one-cycle counter clear strobe
- st  output  2  state: IDLE=00, RUN_UP=01, RUN_DOWN=10, HOLD=11
- busy  output  1  high in RUN_UP/RUN_DOWN
- done  output  1  one-cycle pulse when target reached

## Operation
- Each btn_* passes through a 2-flop synchronizer and a third flop. A command is the rising edge of the sync output (s2 & ~s3). Level-held buttons produce exactly one command.
- Command priority when several occur in the same cycle: clr > stop > up > down.
- clr (any state): st→IDLE; cnt_clr pulses 1 cycle; prescaler cleared; cnt_en not asserted that cycle.
- up: st→RUN_UP from any state. down: st→RUN_DOWN from any state. If the new direction differs from the current run state, the direction switch restarts the prescaler.
- stop: RUN_*→HOLD. In IDLE/HOLD it is ignored.
- Prescaler counts 0..TICK_DIV-1 only in RUN_*. It is reset to 0 on every entry to RUN_*. A tick occurs when it equals TICK_DIV-1, and it then wraps to 0.
- On a tick in RUN_UP/RUN_DOWN:
  - If tgt_en=1 and cnt_val==tgt, no step is issued; st→HOLD; done pulses 1 cycle.
  - Otherwise cnt_en=1 for one cycle, with cnt_dir=1 in RUN_UP and 0 in RUN_DOWN.
- Boundary (without macro): RUN_UP at cnt_val=15 steps up and the counter wraps to 0. RUN_DOWN at cnt_val=0 steps down and wraps to 15.
- If the target already equals cnt_val when a run starts, the first tick yields HOLD + done and no step.
- tgt and tgt_en are sampled at tick time only.
- cnt_dir holds its last value outside RUN_* (reset 1).

## Timing
- Reset values: st=IDLE, cnt_en=0, cnt_dir=1, cnt_clr=0, busy=0, done=0, prescaler=0, sync flops=0.
- rst mid-run: the next edge forces all reset values. Button history is cleared, so a button still held after reset is not a command until it is released and pressed again.
- Command latency: a raw button rising before edge N changes st at edge N+2. cnt_clr is high in the cycle after edge N+2.
- Entering RUN_* at edge E: the first cnt_en is high in the cycle after edge E+TICK_DIV-1+1 (i.e. TICK_DIV cycles after entry). Subsequent pulses follow every TICK_DIV cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- cnt_val is expected to reflect a step one cycle after cnt_en. Since TICK_DIV≥2, feedback is always settled at the next tick.

## Configuration
- UDC_AUTO_REVERSE_EN defined: the ping-pong boundary rule applies:
  - A tick in RUN_UP with cnt_val=15 switches st→RUN_DOWN and issues cnt_en with cnt_dir=0 (counter → 14).
  - A tick in RUN_DOWN with cnt_val=0 switches st→RUN_UP with cnt_dir=1.
  - The prescaler is not restarted on an auto-reverse.
  - The target check takes precedence over reversal.
- Undefined: wrap-around as described in Operation; st changes only by command or target.

## Test plan
- Reset, press up with cnt_val tracked by a model counter, TICK_DIV=4 → cnt_en every 4 cycles, cnt_dir=1, count 0,1,2,3; busy=1, st=01.
- Running up, tgt_en=1, tgt=5 → counter stops at 5; one done pulse; st=11; no further cnt_en.
- Same cycle btn_stop and btn_up edges while RUN_DOWN → st=HOLD (stop wins); then up alone → RUN_UP, first step exactly 4 cycles later.
- RUN_UP from cnt_val=14 → without macro: 15, 0, 1; with UDC_AUTO_REVERSE_EN: 15, 14, 13 and st=10.
- btn_clr held 10 cycles during RUN_DOWN → single cnt_clr pulse 3 cycles after press, st=IDLE, cnt_en stays 0.
- rst asserted mid-run with btn_up held → all outputs at reset values next cycle; no new run until btn_up is released and re-pressed.
